// File: rtl/ycbcr_rgb_reader.sv
// Frame reader for the YCbCr sample store: credit-limited read issue, 3-stage
// YCbCr->RGB fixed-point pipeline, and an output FIFO on a valid/ready stream.
module ycbcr_rgb_reader #(
   parameter int NUM_PIXELS = 1048576,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        mem_en_read,
   input  logic [31:0] Y_O,
   input  logic [31:0] Cb_O,
   input  logic [31:0] Cr_O,
   output logic [7:0]  R,
   output logic [7:0]  G,
   output logic [7:0]  B,
   output logic        rgb_valid,
   input  logic        rgb_ready,
   output logic        busy,
   output logic        done,
   output logic [20:0] pix_count
);
   localparam int STAGES = 2;
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int CW     = AW + 2;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
   typedef struct packed { logic [7:0] y, cb, cr; } ycc_t;
   typedef struct packed { logic [7:0] r, g, b; } rgb_t;

   state_t state, nxt;
   logic   issue, credit;

   // [0] read outstanding at the store, [1] stage A holds a sample, [2] stage B holds products
   logic [STAGES:0] vld_pipe;
   assign mem_en_read = vld_pipe[0];

   logic [20:0] issued;

   // stage A
   ycc_t sa;
   logic signed [17:0] d_b, d_r, p_r, p_gb, p_gr, p_b;
   assign d_b  = $signed({10'd0, sa.cb}) - 18'sd128;
   assign d_r  = $signed({10'd0, sa.cr}) - 18'sd128;
   assign p_r  = d_r * 18'sd359;
   assign p_gb = -(d_b * 18'sd88);
   assign p_gr = -(d_r * 18'sd183);
   assign p_b  = d_b * 18'sd454;

   // stage B
   logic [7:0]         sb_y;
   logic signed [17:0] sb_pr, sb_pgb, sb_pgr, sb_pb;
   logic signed [17:0] yb, sum_r, sum_g, sum_b;
   rgb_t               pix_c;

   function automatic logic [7:0] clamp8(input logic signed [17:0] v);
      if (v < 18'sd0)   return 8'd0;
      if (v > 18'sd255) return 8'hff;
      return v[7:0];
   endfunction

   assign yb    = $signed({10'd0, sb_y});
   assign sum_r = yb + (sb_pr >>> 8);
   assign sum_g = yb + ((sb_pgb + sb_pgr) >>> 8);
   assign sum_b = yb + (sb_pb >>> 8);
   assign pix_c = {clamp8(sum_r), clamp8(sum_g), clamp8(sum_b)};

   // output FIFO
   rgb_t          mem [FIFO_DEPTH];
   rgb_t          head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   fifo_count;
   logic          push, pop;

   assign push      = vld_pipe[STAGES];
   assign rgb_valid = (fifo_count != '0);
   assign pop       = rgb_valid & rgb_ready;
   assign head      = mem[rd_ptr];
   assign R         = rgb_valid ? head.r : 8'd0;
   assign G         = rgb_valid ? head.g : 8'd0;
   assign B         = rgb_valid ? head.b : 8'd0;

   // Everything issued but not yet popped must fit in the FIFO: the store cannot stall.
   logic [1:0]    in_flight;
   logic [CW-1:0] occupancy;
   assign in_flight = 2'(vld_pipe[0]) + 2'(vld_pipe[1]) + 2'(vld_pipe[2]);
   assign occupancy = CW'(fifo_count) + CW'(in_flight);
   assign credit    = occupancy < CW'(FIFO_DEPTH);

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_comb begin
      nxt   = state;
      issue = 1'b0;
      case (state)
         IDLE:  if (start) nxt = ISSUE;
         ISSUE: if (issued < 21'(NUM_PIXELS) && credit) begin
            issue = 1'b1;
            if (issued == 21'(NUM_PIXELS - 1)) nxt = DRAIN;
         end
         DRAIN: if (vld_pipe == '0 && fifo_count == '0) nxt = DONE;
         DONE:  nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         issued    <= '0;
         pix_count <= '0;
      end else begin
         state <= nxt;
         if (state == IDLE && start) begin
            issued    <= '0;
            pix_count <= '0;
         end else begin
            if (issue) issued    <= issued + 21'd1;
            if (pop)   pix_count <= pix_count + 21'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
         sa       <= '0;
         sb_y     <= '0;
         sb_pr    <= '0;
         sb_pgb   <= '0;
         sb_pgr   <= '0;
         sb_pb    <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:0], issue};
         if (vld_pipe[0]) sa <= '{y: Y_O[7:0], cb: Cb_O[7:0], cr: Cr_O[7:0]};
         if (vld_pipe[1]) begin
            sb_y   <= sa.y;
            sb_pr  <= p_r;
            sb_pgb <= p_gb;
            sb_pgr <= p_gr;
            sb_pb  <= p_b;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= pix_c;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   logic unused_hi;
   assign unused_hi = ^{Y_O[31:8], Cb_O[31:8], Cr_O[31:8]};

endmodule

// File: tb/tb_ycbcr_rgb_reader.sv
// Directed bench: three reader instances (4/32/1000-pixel frames) fed by a
// negedge store model; accepted pixels are logged and compared to hand values.
module tb_ycbcr_rgb_reader;
   localparam int NI = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NI-1:0]       start = '0;
   logic [NI-1:0]       rdy   = '0;
   wire  [NI-1:0]       en, vld, busy, done;
   wire  [NI-1:0][7:0]  r, g, b;
   wire  [NI-1:0][20:0] pc;
   logic [NI-1:0][31:0] yo, cbo, cro;

   for (genvar k = 0; k < NI; k++) begin : g_dut
      ycbcr_rgb_reader #(
         .NUM_PIXELS(k == 0 ? 4 : (k == 1 ? 32 : 1000)),
         .FIFO_DEPTH(8)
      ) dut (
         .clk(clk), .rst(rst), .start(start[k]), .mem_en_read(en[k]),
         .Y_O(yo[k]), .Cb_O(cbo[k]), .Cr_O(cro[k]),
         .R(r[k]), .G(g[k]), .B(b[k]), .rgb_valid(vld[k]), .rgb_ready(rdy[k]),
         .busy(busy[k]), .done(done[k]), .pix_count(pc[k])
      );
   end

   // store contents per instance: {Y, Cb, Cr}
   function automatic logic [23:0] smp(input int k, input int idx);
      logic [7:0] yv;
      yv = 8'(idx);
      if (k == 1) return {8'(idx * 7 + 3), 8'd128, 8'd128};
      if (k == 0 && idx < 4) return {8'd128, 8'd128, 8'd128};
      if (k == 0 && idx < 8) begin
         case (idx)
            4:       return {8'd255, 8'd128, 8'd255};
            5:       return {8'd0,   8'd0,   8'd0};
            6:       return {8'd76,  8'd85,  8'd255};
            default: return {8'd128, 8'd255, 8'd128};
         endcase
      end
      return {yv, 8'd128, 8'd128};
   endfunction

   // Cb=Cr=128 samples convert to R=G=B=Y
   function automatic logic [23:0] grey(input int k, input int idx);
      logic [23:0] s;
      s = smp(k, idx);
      return {s[23:16], s[23:16], s[23:16]};
   endfunction

   // hand-computed results for store entries 4..7 of instance 0
   function automatic logic [23:0] exp_ext(input int i);
      case (i)
         0:       return 24'hffa4ff;  // (255,128,255) -> (255,164,255)
         1:       return 24'h008700;  // (0,0,0)       -> (0,135,0)
         2:       return 24'hfe0000;  // (76,85,255)   -> (254,0,0)
         default: return 24'h8054ff;  // (128,255,128) -> (128,84,255)
      endcase
   endfunction

   int ptr [NI]      = '{default: 0};
   int en_cnt [NI]   = '{default: 0};
   int done_cnt [NI] = '{default: 0};
   int got_n [NI]    = '{default: 0};
   logic [23:0] got [NI][0:1023];

   always @(negedge clk) begin
      logic [23:0] s;
      for (int k = 0; k < NI; k++) begin
         if (en[k]) begin
            s = smp(k, ptr[k]);
            yo[k]     <= {24'hdeadbe, s[23:16]};
            cbo[k]    <= {24'hdeadbe, s[15:8]};
            cro[k]    <= {24'hdeadbe, s[7:0]};
            ptr[k]    <= ptr[k] + 1;
            en_cnt[k] <= en_cnt[k] + 1;
         end
         if (vld[k] && rdy[k] && got_n[k] < 1024) begin
            got[k][got_n[k][9:0]] <= {r[k], g[k], b[k]};
            got_n[k] <= got_n[k] + 1;
         end
         if (done[k]) done_cnt[k] <= done_cnt[k] + 1;
      end
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int k);
      start[k] = 1'b1;
      step();
      start[k] = 1'b0;
   endtask

   task automatic wait_done(input int k, input int d0, input int lim);
      int c;
      c = 0;
      while (done_cnt[k] == d0 && c < lim) begin
         step();
         c++;
      end
      chk("done_wait", 32'(done_cnt[k] - d0), 32'd1);
   endtask

   task automatic chk_zero(input string tag, input int k);
      chk({tag, "_en"},   32'(en[k]),   32'd0);
      chk({tag, "_vld"},  32'(vld[k]),  32'd0);
      chk({tag, "_busy"}, 32'(busy[k]), 32'd0);
      chk({tag, "_done"}, 32'(done[k]), 32'd0);
      chk({tag, "_rgb"},  32'({r[k], g[k], b[k]}), 32'd0);
      chk({tag, "_pc"},   32'(pc[k]),   32'd0);
   endtask

   initial begin
      int fe, fv, e0, d0, n0, base;

      step(3);
      chk_zero("reset", 0);
      rst = 1'b0;
      step(2);

      // grey frame, ready held high: latency and count
      rdy[0] = 1'b1;
      e0 = en_cnt[0]; d0 = done_cnt[0]; n0 = got_n[0];
      pulse(0);
      fe = -1; fv = -1;
      for (int c = 0; c < 20; c++) begin
         if (fe < 0 && en[0])  fe = c;
         if (fv < 0 && vld[0]) fv = c;
         step();
      end
      chk("latency",    32'(fv - fe), 32'd3);
      chk("f1_issues",  32'(en_cnt[0] - e0), 32'd4);
      chk("f1_done",    32'(done_cnt[0] - d0), 32'd1);
      chk("f1_pc",      32'(pc[0]), 32'd4);
      chk("f1_busy",    32'(busy[0]), 32'd0);
      chk("f1_npix",    32'(got_n[0] - n0), 32'd4);
      for (int i = 0; i < 4; i++) chk("f1_pix", 32'(got[0][10'(n0 + i)]), 32'h808080);

      // extremes: clamping and floor rounding
      d0 = done_cnt[0]; n0 = got_n[0];
      pulse(0);
      wait_done(0, d0, 50);
      chk("ext_npix", 32'(got_n[0] - n0), 32'd4);
      for (int i = 0; i < 4; i++) chk("ext_pix", 32'(got[0][10'(n0 + i)]), 32'(exp_ext(i)));
      chk("ext_pc", 32'(pc[0]), 32'd4);

      // back-pressure: credit stops issue at FIFO_DEPTH, head held stable
      rdy[1] = 1'b0;
      e0 = en_cnt[1]; d0 = done_cnt[1]; n0 = got_n[1]; base = ptr[1];
      pulse(1);
      step(19);
      chk("stall_issues", 32'(en_cnt[1] - e0), 32'd8);
      chk("stall_en",     32'(en[1]), 32'd0);
      chk("stall_vld",    32'(vld[1]), 32'd1);
      chk("stall_head",   32'({r[1], g[1], b[1]}), 32'(grey(1, base)));
      step(5);
      chk("stall_issues2", 32'(en_cnt[1] - e0), 32'd8);
      chk("stall_head2",   32'({r[1], g[1], b[1]}), 32'(grey(1, base)));
      rdy[1] = 1'b1;
      wait_done(1, d0, 200);
      chk("stall_npix", 32'(got_n[1] - n0), 32'd32);
      for (int i = 0; i < 32; i++) chk("stall_pix", 32'(got[1][10'(n0 + i)]), 32'(grey(1, base + i)));
      chk("stall_total", 32'(en_cnt[1] - e0), 32'd32);
      chk("stall_pc",    32'(pc[1]), 32'd32);

      // random ready on a 1000-sample ramp
      rdy[2] = 1'b0;
      e0 = en_cnt[2]; d0 = done_cnt[2]; n0 = got_n[2]; base = ptr[2];
      pulse(2);
      for (int c = 0; c < 6000 && done_cnt[2] == d0; c++) begin
         rdy[2] = 1'($urandom_range(0, 1));
         step();
      end
      chk("ramp_done", 32'(done_cnt[2] - d0), 32'd1);
      chk("ramp_npix", 32'(got_n[2] - n0), 32'd1000);
      for (int i = 0; i < 1000; i++) chk("ramp_pix", 32'(got[2][10'(n0 + i)]), 32'(grey(2, base + i)));
      chk("ramp_issues", 32'(en_cnt[2] - e0), 32'd1000);
      chk("ramp_pc",     32'(pc[2]), 32'd1000);

      // asynchronous reset in the middle of ISSUE
      rdy[1] = 1'b1;
      d0 = done_cnt[1];
      pulse(1);
      step(6);
      chk("pre_rst_en", 32'(en[1]), 32'd1);
      chk("pre_rst_pc", 32'(pc[1]), 32'd2);
      rst = 1'b1;
      #1;
      chk_zero("midrst", 1);
      step();
      rst = 1'b0;
      step();

      // fresh frame after reset, with an extra start while busy
      e0 = en_cnt[1]; d0 = done_cnt[1]; n0 = got_n[1]; base = ptr[1];
      pulse(1);
      chk("new_pc0", 32'(pc[1]), 32'd0);
      step(3);
      pulse(1);
      wait_done(1, d0, 200);
      chk("new_npix", 32'(got_n[1] - n0), 32'd32);
      for (int i = 0; i < 32; i++) chk("new_pix", 32'(got[1][10'(n0 + i)]), 32'(grey(1, base + i)));
      chk("new_issues", 32'(en_cnt[1] - e0), 32'd32);
      chk("new_pc",     32'(pc[1]), 32'd32);
      step(10);
      chk("busy_start_done", 32'(done_cnt[1] - d0), 32'd1);
      chk("busy_start_idle", 32'(busy[1]), 32'd0);
      chk("busy_start_pc",   32'(pc[1]), 32'd32);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
